// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and big-endian lane helpers for the data-memory arbiter
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = old;
      if (size == SZ_WORD) r = data;
      else if (size == SZ_HALF) r[{~off[1], 4'b0000} +: 16] = data[15:0];
      else r[{~off, 3'b000} +: 8] = data[7:0];
      return r;
   endfunction

   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off);
      return size == SZ_WORD ? word :
             size == SZ_HALF ? {16'h0, word[{~off[1], 4'b0000} +: 16]} :
                               {24'h0, word[{~off, 3'b000} +: 8]};
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian store merge into an old word and right-aligned load extraction
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   assign merged    = lane_merge(old_word, store_data, size, offset);
   assign extracted = lane_extract(old_word, size, offset);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for the single-ported big-endian data memory, with read-modify-write sub-word stores
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DM_SIZE = 1024,
   parameter int RD_LAT  = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_write,
   input  logic [3:0]  req_size,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [32:0] LIMIT = 33'(DM_SIZE);

   state_t      state, next;
   logic        owner, last_grant, wr_q, err_q;
   logic [1:0]  size_q, sz;
   logic [31:0] addr_q, wdata_q, word_q, ad, merged, extracted;
   logic [2:0]  cnt;
   logic [32:0] top;
   logic        win, accept, bad, rd_done;

   assign win     = &req_valid ? ~last_grant : req_valid[1];
   assign accept  = state == IDLE && |req_valid;
   assign sz      = win ? req_size[3:2] : req_size[1:0];
   assign ad      = win ? req_addr[63:32] : req_addr[31:0];
   assign top     = {1'b0, ad[31:2], 2'b00} + 33'd3;
   assign bad     = sz == 2'b11 || (sz == SZ_HALF && ad[0]) || (sz == SZ_WORD && ad[1:0] != 2'b00) || top >= LIMIT;
   assign rd_done = cnt == 3'(RD_LAT - 1);

   dmem_lane_align u_align (
      .old_word   (word_q),
      .store_data (wdata_q),
      .size       (size_q),
      .offset     (addr_q[1:0]),
      .merged     (merged),
      .extracted  (extracted)
   );

   // loads and sub-word stores read first, word stores write directly, errors skip the memory
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (accept) next = bad ? RESP : (req_write[win] && sz == SZ_WORD) ? WR : RD;
         RD:      if (rd_done) next = wr_q ? WR : RESP;
         WR:      next = RESP;
         default: next = IDLE;
      endcase
   end

   // state register; async reset aborts any access in flight
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= next;

   // latch the winner at accept, count RD wait cycles and capture the read word on the last one
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         cnt        <= '0;
      end else begin
         if (accept) begin
            owner      <= win;
            last_grant <= win;
            wr_q       <= req_write[win];
            err_q      <= bad;
            size_q     <= sz;
            addr_q     <= ad;
            wdata_q    <= win ? req_wdata[63:32] : req_wdata[31:0];
            cnt        <= '0;
         end
         if (state == RD) begin
            cnt <= cnt + 3'd1;
            if (rd_done) word_q <= mem_rdata;
         end
      end

   assign req_ready  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign mem_read   = state == RD;
   assign mem_write  = state == WR;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = state == WR ? merged : '0;
   assign resp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign resp_err   = state == RESP && err_q;
   assign resp_rdata = (state == RESP && !wr_q && !err_q) ? extracted : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a byte-array reference model of the arbitrated memory
module tb_dmem_arbiter;

   localparam int DM  = 1024;
   localparam int LAT = 1;

   logic        clock = 0, reset_n = 0;
   logic [1:0]  req_valid, req_ready, req_write, resp_valid;
   logic [3:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        resp_err, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [1:0]  v3, rdy3, rv3;
   logic        err3, mr3, mwr3;
   logic [31:0] rd3, ma3, mw3;

   always #5 clock = ~clock;

   dmem_arbiter #(.DM_SIZE(DM), .RD_LAT(LAT)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));

   dmem_arbiter #(.DM_SIZE(DM), .RD_LAT(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .req_valid(v3), .req_ready(rdy3),
      .req_write(2'b00), .req_size(4'b1010), .req_addr(64'h40), .req_wdata(64'h0),
      .resp_valid(rv3), .resp_err(err3), .resp_rdata(rd3),
      .mem_read(mr3), .mem_write(mwr3), .mem_addr(ma3), .mem_wdata(mw3),
      .mem_rdata(ma3 == 32'h40 ? 32'hCAFEF00D : 32'h0));

   logic [7:0]  dm   [0:DM-1];
   logic [7:0]  refm [0:DM-1];
   logic [9:0]  ma;
   logic [31:0] last_wdata = 0, last_waddr = 0, last_rdata = 0;

   assign ma        = mem_addr[9:0];
   assign mem_rdata = {dm[ma], dm[ma + 10'd1], dm[ma + 10'd2], dm[ma + 10'd3]};

   always @(posedge clock)
      if (mem_write) begin
         dm[ma] = mem_wdata[31:24];
         dm[ma + 10'd1] = mem_wdata[23:16];
         dm[ma + 10'd2] = mem_wdata[15:8];
         dm[ma + 10'd3] = mem_wdata[7:0];
         last_wdata = mem_wdata;
         last_waddr = mem_addr;
      end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {int t; logic [1:0] v; logic e; logic [31:0] d;} exp_t;
   exp_t q[$];
   int   glog[$];
   int   total = 0, bad = 0;
   int   exp_rd = 0, exp_wr = 0, act_rd = 0, act_wr = 0;
   int   busy_until = -1, acc_cyc = 0, last_lat = 0;
   logic model_lg = 1'b1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, want, $time);
      end
   endtask

   // Reference: memory as a big-endian byte array, latency and strobe counts from the access kind.
   task automatic accept_model(input int p);
      logic [1:0] s; logic [31:0] a, w, d; logic e; int l;
      s = req_size[2*p +: 2];
      a = req_addr[32*p +: 32];
      w = req_wdata[32*p +: 32];
      e = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
          (64'(a & ~32'd3) + 64'd3 >= 64'(DM));
      d = 0;
      if (e) l = 1;
      else if (!req_write[p]) begin
         l = LAT + 1;
         exp_rd += LAT;
         d = s == 2'd0 ? {24'h0, refm[a]} : s == 2'd1 ? {16'h0, refm[a], refm[a+1]} :
             {refm[a], refm[a+1], refm[a+2], refm[a+3]};
      end else begin
         l = s == 2'd2 ? 2 : LAT + 2;
         exp_wr++;
         if (s != 2'd2) exp_rd += LAT;
         if (s == 2'd0) refm[a] = w[7:0];
         else if (s == 2'd1) begin refm[a] = w[15:8]; refm[a+1] = w[7:0]; end
         else for (int i = 0; i < 4; i++) refm[a+i] = w[31-8*i -: 8];
      end
      model_lg = p[0];
      acc_cyc = cyc;
      busy_until = cyc + l;
      glog.push_back(p);
      q.push_back('{cyc + l, p[0] ? 2'b10 : 2'b01, e, d});
   endtask

   always @(negedge clock)
      if (reset_n) begin
         exp_t e;
         logic [1:0] ev;
         ev = 2'b00;
         if (q.size() != 0 && q[0].t < cyc) begin
            chk("resp_missing", 64'(cyc), 64'(q[0].t));
            void'(q.pop_front());
         end
         if (q.size() != 0 && q[0].t == cyc) begin
            e = q.pop_front();
            ev = e.v;
         end
         chk("resp_valid", resp_valid, ev);
         if (ev != 2'b00) begin
            chk("resp_err", resp_err, e.e);
            chk("resp_rdata", resp_rdata, e.d);
            last_rdata = resp_rdata;
            last_lat = cyc - acc_cyc;
         end
         chk("strobe_excl", mem_read & mem_write, 0);
         act_rd += mem_read;
         act_wr += mem_write;
      end

   task automatic run(input logic [1:0] en, input logic [1:0] wr, input logic [3:0] sz,
                      input logic [63:0] ad, input logic [63:0] wd);
      logic [1:0] pend, er;
      int p;
      pend = en;
      #1;
      req_write = wr; req_size = sz; req_addr = ad; req_wdata = wd; req_valid = pend;
      for (int k = 0; k < 40 && pend != 2'b00; k++) begin
         @(negedge clock);
         er = (cyc > busy_until) ? (((pend == 2'b11) ? !model_lg : pend[1]) ? 2'b10 : 2'b01) : 2'b00;
         chk("req_ready", req_ready, er);
         if (er != 2'b00) begin
            p = er[1] ? 1 : 0;
            accept_model(p);
            pend[p] = 1'b0;
         end
         @(posedge clock);
         #1 req_valid = pend;
      end
      if (pend != 2'b00) begin
         chk("grant_timeout", pend, 0);
         req_valid = 2'b00;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clock);
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      int r0, w0, n, rc, c0, mism;
      req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0; v3 = 0;
      for (int i = 0; i < DM; i++) begin dm[i] = 0; refm[i] = 0; end
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset_n = 1;
      @(posedge clock);

      run(2'b01, 2'b01, 4'b0010, 64'h10, 64'hDEADBEEF); drain();
      chk("wst_addr", last_waddr, 32'h10);
      chk("wst_lat", last_lat, 2);
      chk("wst_writes", act_wr, 1);
      run(2'b01, 2'b00, 4'b0010, 64'h10, 64'h0); drain();
      chk("wld_data", last_rdata, 32'hDEADBEEF);
      chk("wld_lat", last_lat, 2);

      run(2'b01, 2'b01, 4'b0010, 64'h10, 64'h11223344); drain();
      run(2'b01, 2'b01, 4'b0000, 64'h11, 64'hAA); drain();
      chk("bst_merge", last_wdata, 32'h11AA3344);
      chk("bst_lat", last_lat, 3);
      run(2'b01, 2'b00, 4'b0010, 64'h10, 64'h0); drain();
      chk("merged_load", last_rdata, 32'h11AA3344);
      run(2'b01, 2'b00, 4'b0001, 64'h12, 64'h0); drain();
      chk("half_load", last_rdata, 32'h00003344);
      run(2'b10, 2'b00, 4'b0000, {32'h13, 32'h0}, 64'h0); drain();
      chk("p1_byte_load", last_rdata, 32'h00000044);

      glog.delete();
      repeat (4) begin
         run(2'b11, 2'b00, 4'b0110, {32'h12, 32'h10}, 64'h0);
         drain();
      end
      chk("tie_count", glog.size(), 8);
      for (int i = 0; i < glog.size(); i++) chk("tie_order", glog[i], i % 2);

      r0 = act_rd; w0 = act_wr;
      run(2'b01, 2'b00, 4'b0010, 64'h13, 64'h0); drain(); chk("err_mis_word_lat", last_lat, 1);
      run(2'b01, 2'b01, 4'b0001, 64'h21, 64'h1234); drain(); chk("err_mis_half_lat", last_lat, 1);
      run(2'b01, 2'b00, 4'b0011, 64'h10, 64'h0); drain(); chk("err_size_lat", last_lat, 1);
      run(2'b01, 2'b00, 4'b0010, 64'(DM - 2), 64'h0); drain(); chk("err_range_lat", last_lat, 1);
      run(2'b10, 2'b00, 4'b1000, {32'(DM), 32'h0}, 64'h0); drain(); chk("err_range_p1_lat", last_lat, 1);
      chk("err_no_read", act_rd, r0);
      chk("err_no_write", act_wr, w0);
      run(2'b01, 2'b00, 4'b0010, 64'(DM - 4), 64'h0); drain(); chk("last_word_lat", last_lat, 2);

      #1;
      req_valid = 2'b01; req_write = 2'b01; req_size = 4'b0000; req_addr = 64'h14; req_wdata = 64'h55;
      @(negedge clock);
      chk("abort_ready", req_ready, 2'b01);
      @(posedge clock);
      #1 req_valid = 2'b00;
      chk("abort_in_rd", mem_read, 1);
      reset_n = 0;
      #1;
      chk("abort_read_drop", mem_read, 0);
      chk("abort_no_write", mem_write, 0);
      chk("abort_no_resp", resp_valid, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      model_lg = 1'b1;
      busy_until = cyc - 1;
      chk("abort_mem", {dm[20], dm[21], dm[22], dm[23]}, 32'h0);
      glog.delete();
      run(2'b11, 2'b00, 4'b1010, {32'h14, 32'h10}, 64'h0); drain();
      chk("post_rst_first", glog[0], 0);

      #1 v3 = 2'b01;
      @(negedge clock);
      chk("l3_ready", rdy3, 2'b01);
      c0 = cyc;
      @(posedge clock);
      #1 v3 = 2'b00;
      n = 0; rc = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         n += mr3;
         if (rv3 != 2'b00 && rc < 0) begin
            rc = cyc - c0;
            chk("l3_owner", rv3, 2'b01);
            chk("l3_err", err3, 0);
            chk("l3_data", rd3, 32'hCAFEF00D);
         end
      end
      chk("l3_rd_cycles", n, 3);
      chk("l3_resp_lat", rc, 4);
      chk("l3_no_write", {mwr3, mw3}, 0);

      chk("queue_empty", q.size(), 0);
      chk("rd_strobes", act_rd, exp_rd);
      chk("wr_strobes", act_wr, exp_wr);
      mism = 0;
      for (int i = 0; i < DM; i++) if (dm[i] !== refm[i]) mism++;
      chk("mem_image", mism, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-ported byte-addressed big-endian data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader). Sequences every access through a small FSM, converting byte/halfword stores into read-modify-write word cycles. Sits between the requesters and the data memory's MemoryRead/MemoryWrite/Address/InputData/OutputData interface.

Parameters:
DM_SIZE, 1024, memory size in bytes; word addresses with addr+3 >= DM_SIZE are rejected.
RD_LAT, 1, cycles mem_read is held before mem_rdata is captured (1..4).

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid; bit0 = port 0
req_ready  out  2  per-port accept; one-hot or zero
req_write  in  2  per-port 1 = store, 0 = load
req_size  in  4  per-port {p1,p0}: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 illegal
req_addr  in  64  per-port {p1,p0} byte address
req_wdata  in  64  per-port {p1,p0} store data, right-aligned
resp_valid  out  2  one-cycle completion pulse to the owning port
resp_err  out  1  qualifies resp_valid: misaligned, illegal size or out-of-range
resp_rdata  out  32  load data, right-aligned, zero-extended
mem_read  out  1  to memory MemoryRead
mem_write  out  1  to memory MemoryWrite
mem_addr  out  32  to memory Address, always word-aligned
mem_wdata  out  32  to memory InputData
mem_rdata  in  32  from memory OutputData

Behaviour:
- Reset: state IDLE; req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; last_grant=1 (port 0 wins first tie).
- Arbitration is in IDLE only; req_ready is combinational from req_valid. One valid request wins. Two valid requests: winner is the port != last_grant. Winner's fields are latched and last_grant is updated in the accept cycle. No preemption.
- Checks at accept: size 11, half with addr[0]=1, word with addr[1:0]!=0, or (addr & ~3)+3 >= DM_SIZE -> ERR. ERR goes directly to RESP with resp_err=1 and no memory strobe.
- FSM states: IDLE, RD, WR, RESP.
- Load: IDLE->RD. mem_read=1 for RD_LAT cycles. mem_rdata is captured on the last RD cycle. RD->RESP.
- Word store: IDLE->WR. mem_write=1 with full word for exactly 1 cycle. WR->RESP.
- Byte/half store: IDLE->RD (capture old word) ->WR with merged word ->RESP. Only the addressed lanes are replaced. Big-endian lanes: offset 0 = bits 31:24; half offset 0 = bits 31:16.
- mem_addr = {addr[31:2],2'b00}; it is stable through RD and WR. mem_read and mem_write are never high together.
- RESP: resp_valid[owner]=1 for one cycle. resp_rdata (loads only) = selected byte/half shifted to bits [7:0]/[15:0] and zero-extended; 0 for stores and errors. Then RESP->IDLE. Next grant is possible the cycle after RESP.
- Latency, accept to resp_valid: error 1; word store 2; load RD_LAT+1; sub-word store RD_LAT+2.
- A requester may drop req_valid while not granted; no state is kept for it.
- reset_n asserted mid-access aborts immediately: strobes drop asynchronously, no response is issued, and a partially merged store is never written.

Decomposition:
- Shared package dmem_pkg holds: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD); FSM state enum; lane-merge and lane-extract functions, with big-endian offset mapping.
- One sub-module, dmem_lane_align: combinational merge of store data into the old word, plus extraction of load data. It is reused later by the CPU load/store unit.

Test Plan:
- Port0 word store 0xDEADBEEF @0x10, then load @0x10 -> mem_write 1 cycle with mem_addr=0x10; load resp_rdata=0xDEADBEEF, resp_err=0; accept-to-resp latency 2 then 2 (RD_LAT=1).
- Byte store 0xAA @0x11 over 0x11223344, then word load @0x10 -> RD then WR with mem_wdata=0x11AA3344; load returns 0x11AA3344. Half load @0x12 returns 0x00003344.
- Both ports valid in the same cycle, back-to-back, 4 times -> grants alternate 0,1,0,1; resp_valid pulses only on the owning bit.
- Word load @0x13, half store @0x21, size 11, word @DM_SIZE-2 -> each gives resp_err=1 after 1 cycle; mem_read=mem_write=0 throughout.
- reset_n low during RD of a byte store -> mem_read drops immediately; no mem_write and no resp_valid; memory word unchanged; after release, port 0 wins the first tie.
- RD_LAT=3 load -> mem_read high exactly 3 cycles; resp_valid on the 4th cycle after accept.
